// File: rtl/nms_score_packer.sv
// rtl/nms_score_packer.sv - FAST score packer: coordinate tagging, border mask, saturation, flush row
module nms_score_packer #(
    parameter int COL_NUM   = 640,
    parameter int ROW_NUM   = 480,
    parameter int FAST_SIZE = 7,
    parameter int SCORE_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               frame_start,
    input  logic               score_vld,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               iscorner_in,
    output logic [33:0]        data_out,
    output logic               out_vld,
    output logic               xy_coord_vld,
    output logic               score_eol,
    output logic               frame_done,
    output logic               frame_abort
);

    localparam int B = FAST_SIZE / 2;
    localparam logic [9:0] X_LAST  = 10'(COL_NUM - 1);
    localparam logic [9:0] Y_LAST  = 10'(ROW_NUM - 1);
    localparam logic [9:0] Y_FLUSH = 10'(ROW_NUM);
    localparam logic [9:0] X_LO    = 10'(B);
    localparam logic [9:0] X_HI    = 10'(COL_NUM - 1 - B);
    localparam logic [9:0] Y_LO    = 10'(B);
    localparam logic [9:0] Y_HI    = 10'(ROW_NUM - 1 - B);
    localparam logic [SCORE_W-1:0] SAT = SCORE_W'(13'h1FFF);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t     state, state_nxt, base_state;
    logic [9:0] x_cnt, y_cnt, x_nxt, y_nxt, base_x, base_y;
    logic [9:0] wx, wy;
    logic       emit, abort_nxt, done_nxt;
    logic       in_region, corner;
    logic [12:0] score_sat;

    // State and coordinate counters; frozen whenever ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (ce) begin
            state <= state_nxt;
            x_cnt <= x_nxt;
            y_cnt <= y_nxt;
        end
    end

    // Next-state: frame_start restarts the frame first, so a same-cycle strobe becomes pixel (0,0).
    always_comb begin
        base_state = frame_start ? RUN : state;
        base_x     = frame_start ? 10'd0 : x_cnt;
        base_y     = frame_start ? 10'd0 : y_cnt;
        state_nxt  = base_state;
        x_nxt      = base_x;
        y_nxt      = base_y;
        wx         = base_x;
        wy         = base_y;
        emit       = 1'b0;
        done_nxt   = 1'b0;
        abort_nxt  = frame_start && (state != IDLE);
        case (base_state)
            IDLE: begin
            end
            RUN: begin
                if (score_vld) begin
                    emit = 1'b1;
                    if (base_x == X_LAST) begin
                        x_nxt = '0;
                        if (base_y == Y_LAST) begin
                            y_nxt     = Y_FLUSH;
                            state_nxt = FLUSH;
                        end else begin
                            y_nxt = base_y + 10'd1;
                        end
                    end else begin
                        x_nxt = base_x + 10'd1;
                    end
                end
            end
            FLUSH: begin
                emit = 1'b1;
                if (base_x == X_LAST) begin
                    x_nxt     = '0;
                    y_nxt     = '0;
                    state_nxt = DONE;
                end else begin
                    x_nxt = base_x + 10'd1;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Border mask and saturation; flush words fall outside the region (y=ROW_NUM) so they carry zeros.
    always_comb begin
        in_region = (wx >= X_LO) && (wx <= X_HI) && (wy >= Y_LO) && (wy <= Y_HI);
        corner    = iscorner_in && in_region && (base_state == RUN);
        score_sat = (score_in > SAT) ? 13'h1FFF : score_in[12:0];
        if (!corner) begin
            score_sat = '0;
        end
    end

    // Registered outputs; data_out holds its last word on cycles without a new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out     <= '0;
            out_vld      <= 1'b0;
            xy_coord_vld <= 1'b0;
            score_eol    <= 1'b0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
        end else if (ce) begin
            out_vld      <= emit;
            xy_coord_vld <= emit && in_region;
            score_eol    <= emit && (wx == X_LAST);
            frame_done   <= done_nxt;
            frame_abort  <= abort_nxt;
            if (emit) begin
                data_out <= {wx, wy, corner, score_sat};
            end
        end
    end

endmodule

// File: tb/tb_nms_score_packer.sv
// tb/tb_nms_score_packer.sv - directed self-checking bench for nms_score_packer (8x8 frame)
module tb_nms_score_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        frame_start;
    logic        score_vld;
    logic [15:0] score_in;
    logic        iscorner_in;
    logic [33:0] data_out;
    logic        out_vld;
    logic        xy_coord_vld;
    logic        score_eol;
    logic        frame_done;
    logic        frame_abort;

    int checks   = 0;
    int failures = 0;

    nms_score_packer #(
        .COL_NUM(8), .ROW_NUM(8), .FAST_SIZE(7), .SCORE_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .frame_start(frame_start),
        .score_vld(score_vld), .score_in(score_in), .iscorner_in(iscorner_in),
        .data_out(data_out), .out_vld(out_vld), .xy_coord_vld(xy_coord_vld),
        .score_eol(score_eol), .frame_done(frame_done), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pix_s(input int i);
        return (i == 0 || i == 27) ? 16'h2345 : 16'(i * 300);
    endfunction

    function automatic logic pix_c(input int i);
        return (i % 2 == 0) || (i == 27);
    endfunction

    function automatic logic [33:0] exp_word(input int i);
        int x, y;
        logic v, c;
        logic [12:0] s;
        x = i % 8;
        y = i / 8;
        v = (x >= 3) && (x <= 4) && (y >= 3) && (y <= 4);
        c = pix_c(i) & v;
        s = !c ? 13'd0 : (pix_s(i) > 16'h1FFF) ? 13'h1FFF : pix_s(i)[12:0];
        return {10'(x), 10'(y), c, s};
    endfunction

    task automatic drive_pix(input int i);
        int x, y;
        x = i % 8;
        y = i / 8;
        score_vld   = 1'b1;
        score_in    = pix_s(i);
        iscorner_in = pix_c(i);
        step();
        chk("pix_vld", 64'(out_vld), 64'd1);
        chk("pix_word", 64'(data_out), 64'(exp_word(i)));
        chk("pix_xyvld", 64'(xy_coord_vld), 64'((x >= 3) && (x <= 4) && (y >= 3) && (y <= 4)));
        chk("pix_eol", 64'(score_eol), 64'(x == 7));
        chk("pix_done", 64'(frame_done), 64'd0);
    endtask

    task automatic flush_words(input int n);
        score_vld = 1'b0;
        for (int x = 0; x < n; x++) begin
            step();
            chk("fl_vld", 64'(out_vld), 64'd1);
            chk("fl_word", 64'(data_out), 64'({10'(x), 10'd8, 14'd0}));
            chk("fl_xyvld", 64'(xy_coord_vld), 64'd0);
            chk("fl_eol", 64'(score_eol), 64'(x == 7));
            chk("fl_done", 64'(frame_done), 64'd0);
        end
    endtask

    task automatic check_done();
        step();
        chk("done_pulse", 64'(frame_done), 64'd1);
        chk("done_novld", 64'(out_vld), 64'd0);
        step();
        chk("done_clear", 64'(frame_done), 64'd0);
    endtask

    initial begin
        logic [33:0] held;
        rst_n = 1'b0; ce = 1'b1; frame_start = 1'b0;
        score_vld = 1'b0; score_in = '0; iscorner_in = 1'b0;

        // reset state with ce=1
        repeat (3) begin
            step();
            chk("rst_vld", 64'(out_vld), 64'd0);
            chk("rst_data", 64'(data_out), 64'd0);
            chk("rst_flags", 64'({xy_coord_vld, score_eol, frame_done, frame_abort}), 64'd0);
        end
        rst_n = 1'b1;
        score_vld = 1'b1;
        repeat (3) begin
            step();
            chk("idle_drop", 64'(out_vld), 64'd0);
        end

        // full 8x8 frame, then flush row and frame_done
        score_vld = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("start_novld", 64'(out_vld), 64'd0);
        chk("start_noabort", 64'(frame_abort), 64'd0);
        for (int i = 0; i < 64; i++) begin
            drive_pix(i);
            if (i == 0) chk("border_0_0", 64'(data_out[13:0]), 64'd0);
            if (i == 27) chk("sat_3_3", 64'(data_out[12:0]), 64'h1FFF);
        end
        flush_words(8);
        check_done();

        // frame_start with strobe from IDLE, ce freeze mid-row
        frame_start = 1'b1;
        drive_pix(0);
        chk("idle_start_noabort", 64'(frame_abort), 64'd0);
        frame_start = 1'b0;
        drive_pix(1);
        drive_pix(2);
        held = exp_word(2);
        ce = 1'b0;
        score_vld = 1'b1;
        score_in = 16'h0123;
        iscorner_in = 1'b1;
        repeat (5) begin
            step();
            chk("frz_vld", 64'(out_vld), 64'd1);
            chk("frz_data", 64'(data_out), 64'(held));
        end
        ce = 1'b1;
        for (int i = 3; i < 20; i++) drive_pix(i);

        // abort after 20 pixels; same-cycle strobe is pixel (0,0) of the new frame
        frame_start = 1'b1;
        drive_pix(0);
        chk("abort_pulse", 64'(frame_abort), 64'd1);
        frame_start = 1'b0;
        drive_pix(1);
        chk("abort_clear", 64'(frame_abort), 64'd0);
        for (int i = 2; i < 64; i++) drive_pix(i);
        flush_words(8);
        check_done();

        // async reset mid-flush
        frame_start = 1'b1;
        drive_pix(0);
        frame_start = 1'b0;
        for (int i = 1; i < 64; i++) drive_pix(i);
        flush_words(3);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(out_vld), 64'd0);
        chk("arst_data", 64'(data_out), 64'd0);
        chk("arst_flags", 64'({xy_coord_vld, score_eol, frame_done, frame_abort}), 64'd0);
        step();
        rst_n = 1'b1;
        score_vld = 1'b1;
        repeat (12) begin
            step();
            chk("arst_drop", 64'(out_vld), 64'd0);
            chk("arst_nodone", 64'(frame_done), 64'd0);
        end
        frame_start = 1'b1;
        drive_pix(0);
        frame_start = 1'b0;
        chk("arst_restart_noabort", 64'(frame_abort), 64'd0);
        score_vld = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
